// File: rtl/fir_sym_mc_serial.sv
// Two-channel symmetric even-length FIR: one shared pre-adder, multiplier and accumulator, with run-time loadable coefficients.
// Latency: an accept at edge 0 gives an out_valid strobe HALF_TAPS+1 cycles later. At most one sample is accepted per HALF_TAPS+2 cycles.
// Backpressure: in_ready is high only in IDLE, and a held sample is taken once. Optional rounding is enabled by defining FIR_ROUND_EN.
module fir_sym_mc_serial #(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int HALF_TAPS = 11,
  parameter int ACC_W     = 21,
  parameter int OUT_W     = 20,
  parameter int OUT_SHIFT = 1
) (
  input  logic                         CLK_Filter,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_ch,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         coef_we,
  input  logic [$clog2(HALF_TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]            coef_data,
  output logic                         out_valid,
  output logic                         out_ch,
  output logic [OUT_W-1:0]             out_data,
  output logic                         busy
);

  localparam int N  = 2 * HALF_TAPS;
  localparam int AW = $clog2(HALF_TAPS);
  localparam int NW = $clog2(N);
  localparam int PW = DATA_W + 1 + COEF_W;
  localparam int SW = ACC_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t              state;
  logic                ch;
  logic [AW-1:0]       idx;
  logic [ACC_W-1:0]    acc;
  logic [COEF_W-1:0]   coef [HALF_TAPS];
  logic [DATA_W-1:0]   dl   [2][N];

  logic [NW-1:0]       near_idx;
  logic [NW-1:0]       far_idx;
  logic [DATA_W:0]     pre;
  logic [PW-1:0]       prod;
  logic [ACC_W-1:0]    acc_sum;
  logic [SW-1:0]       sh;
  logic                ovf;
  logic [OUT_W-1:0]    sat_val;

  // The tap pair for this step is the newest-side index and its mirror from the oldest end.
  assign near_idx = NW'(idx);
  assign far_idx  = NW'(N - 1) - NW'(idx);
  assign pre      = {1'b0, dl[ch][near_idx]} + {1'b0, dl[ch][far_idx]};
  assign prod     = PW'(pre) * PW'(coef[idx]);
  assign acc_sum  = acc + ACC_W'(prod);

`ifdef FIR_ROUND_EN
  // Round half up. The add uses one extra bit so a full accumulator cannot wrap.
  localparam logic [SW-1:0] RND = (SW'(1) << OUT_SHIFT) >> 1;
  assign sh = ({1'b0, acc} + RND) >> OUT_SHIFT;
`else
  assign sh = {1'b0, acc} >> OUT_SHIFT;
`endif

  // The result overflows when any bit at or above OUT_W survives the shift.
  generate
    if (OUT_W < SW) begin : g_ovf
      assign ovf = |sh[SW-1:OUT_W];
    end else begin : g_no_ovf
      assign ovf = 1'b0;
    end
  endgenerate

  assign sat_val  = ovf ? {OUT_W{1'b1}} : OUT_W'(sh);
  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;

  // Sequencer: accept and shift in IDLE, one tap pair per cycle in MAC, then publish in OUT.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch        <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < HALF_TAPS; k++) coef[k] <= '0;
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < N; i++) dl[c][i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // Coefficient writes land only while idle. Out-of-range addresses are ignored.
          if (coef_we && (coef_addr <= AW'(HALF_TAPS - 1)))
            coef[coef_addr] <= coef_data;
          if (in_valid) begin
            dl[in_ch][0] <= in_data;
            for (int i = 1; i < N; i++) dl[in_ch][i] <= dl[in_ch][i-1];
            ch    <= in_ch;
            acc   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          idx <= idx + AW'(1);
          if (idx == AW'(HALF_TAPS - 1)) state <= S_OUT;
        end
        S_OUT: begin
          out_data  <= sat_val;
          out_ch    <= ch;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sym_mc_serial.sv
// Bench for fir_sym_mc_serial: a default-width instance and a 12-bit-output instance share the same stimulus.
// A tap-sum reference model predicts every result. One compare process checks strobes, latency and held outputs.
// Literal expectations pin the model at known points. Honours FIR_ROUND_EN when it is defined.
module tb_fir_sym_mc_serial;
  localparam int HT = 11;
  localparam int N  = 2 * HT;
  localparam int OS = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ch, coef_we;
  logic [7:0] in_data, coef_data;
  logic [3:0] coef_addr;
  logic       in_ready, out_valid, out_ch, busy;
  logic [19:0] out_data;
  logic       s_in_ready, s_out_valid, s_out_ch, s_busy;
  logic [11:0] s_out_data;

  always #5 clk = ~clk;

  fir_sym_mc_serial u_dut (
    .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .busy(busy));

  fir_sym_mc_serial #(.OUT_W(12)) u_sat (
    .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .out_valid(s_out_valid), .out_ch(s_out_ch),
    .out_data(s_out_data), .busy(s_busy));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  longint last_d = 0, last_s = 0, last_ch = 0;

  typedef struct { bit ch; longint acc; int cyc; } exp_t;
  exp_t q[$];
  int unsigned hist [2][N];
  int unsigned mcoef [HT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sat_of(input longint acc, input int ow);
    longint sh;
`ifdef FIR_ROUND_EN
    sh = (acc + ((longint'(1) << OS) >> 1)) >> OS;
`else
    sh = acc >> OS;
`endif
    if (sh >= (longint'(1) << ow)) return (longint'(1) << ow) - 1;
    return sh;
  endfunction

  // Reference: the filter output is the sum over the unique taps of coef times the mirrored sample pair.
  function automatic longint model_accept(input bit c, input int unsigned d, input int cy);
    longint acc = 0;
    exp_t e;
    for (int i = N - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
    hist[c][0] = d;
    for (int k = 0; k < HT; k++)
      acc += longint'(mcoef[k]) * longint'(hist[c][k] + hist[c][N-1-k]);
    e.ch = c; e.acc = acc; e.cyc = cy;
    q.push_back(e);
    return acc;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) for (int i = 0; i < N; i++) hist[c][i] = 0;
    for (int k = 0; k < HT; k++) mcoef[k] = 0;
    q.delete();
  endfunction

  // Compare process: each strobe must match the next predicted result, arriving 12 cycles after its accept.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_ch", out_ch, e.ch);
          check("out_data", out_data, sat_of(e.acc, 20));
          check("sat_out_data", s_out_data, sat_of(e.acc, 12));
          check("sat_out_valid", s_out_valid, 1);
          check("latency", cyc - e.cyc, HT + 1);
          last_d = sat_of(e.acc, 20); last_s = sat_of(e.acc, 12); last_ch = e.ch;
        end
      end else begin
        check("hold_out_data", out_data, last_d);
        check("hold_out_ch", out_ch, last_ch);
        check("hold_sat_data", s_out_data, last_s);
        check("sat_no_strobe", s_out_valid, 0);
      end
    end
  end

  // Offer one sample and wait, with a bound, for it to be accepted. An optional coef write rides on the accept cycle.
  task automatic send(input bit c, input int unsigned d, input bit do_cw,
                      input int unsigned ca, input int unsigned cd, output longint acc);
    int n = 0;
    acc = -1;
    in_valid = 1'b1; in_ch = c; in_data = 8'(d);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (do_cw) begin coef_we = 1'b1; coef_addr = 4'(ca); coef_data = 8'(cd); end
    @(posedge clk); #1;
    if (do_cw && ca < HT) mcoef[ca] = cd;
    acc = model_accept(c, d, cyc);
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic load_coef(input int unsigned a, input int unsigned d);
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = 8'(d);
    @(posedge clk); #1;
    if (a < HT) mcoef[a] = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 400) begin @(negedge clk); n++; end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic pulse_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    last_d = 0; last_s = 0; last_ch = 0;
    chk_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint a;
    int acc_at[$];
    int i;
    rst_n = 1'b0; in_valid = 1'b0; in_ch = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Impulse response with unity coefficients.
    for (int k = 0; k < HT; k++) load_coef(k, 1);
    send(0, 100, 0, 0, 0, a);
    check("pin_impulse", sat_of(a, 20), 50);
    for (int k = 0; k < 21; k++) begin
      send(0, 0, 0, 0, 0, a);
      check("pin_impulse_tail", sat_of(a, 20), 50);
    end
    send(0, 0, 0, 0, 0, a);
    check("pin_impulse_gone", sat_of(a, 20), 0);
    drain();

    // A constant RED input fills the line while the IR channel stays at zero.
    for (int k = 0; k < 22; k++) begin
      send(0, 255, 0, 0, 0, a);
      if (k % 7 == 0) begin
        longint b;
        send(1, 0, 0, 0, 0, b);
        check("pin_ir_zero", sat_of(b, 20), 0);
      end
    end
    check("pin_const_255", sat_of(a, 20), 2805);
    drain();

    // Full-scale coefficients overflow the 12-bit instance.
    for (int k = 0; k < HT; k++) load_coef(k, 255);
    for (int k = 0; k < 22; k++) send(0, 255, 0, 0, 0, a);
    check("pin_raw_full", a >> OS, 715275);
    check("pin_sat_12", sat_of(a, 12), 4095);
    drain();

    // Hold in_valid for 30 cycles and attempt coefficient writes while the block is busy.
    in_valid = 1'b1; in_ch = 1'b1; in_data = 8'd77;
    i = 0;
    while (i < 30) begin
      if (in_ready) begin
        acc_at.push_back(i);
        coef_we = 1'b0;
        @(posedge clk); #1;
        a = model_accept(1, 77, cyc);
        @(negedge clk);
      end else begin
        coef_we = 1'b1; coef_addr = 4'(i % HT); coef_data = 8'd3;
        @(negedge clk);
      end
      i++;
    end
    in_valid = 1'b0; coef_we = 1'b0;
    check("held_accepts", acc_at.size(), 3);
    if (acc_at.size() == 3) begin
      check("held_acc0", acc_at[0], 0);
      check("held_acc1", acc_at[1], 13);
      check("held_acc2", acc_at[2], 26);
    end
    drain();

    // Random traffic, including coef writes on the accept cycle and writes to out-of-range addresses.
    for (int k = 0; k < HT; k++) load_coef(k, $urandom_range(0, 255));
    for (int k = 0; k < 60; k++) begin
      send(1'($urandom_range(0, 1)), $urandom_range(0, 255), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 15), $urandom_range(0, 255), a);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 20)) @(negedge clk);
    end
    drain();

    // Reset in the middle of a MAC: the pending result is discarded and the block restarts from clean state.
    send(0, 200, 0, 0, 0, a);
    repeat (4) @(negedge clk);
    pulse_reset();
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_data", out_data, 0);
    repeat (20) @(negedge clk);
    for (int k = 0; k < HT; k++) load_coef(k, 1);
    send(0, 100, 0, 0, 0, a);
    check("pin_fresh_impulse", sat_of(a, 20), 50);
    drain();

    // Single-tap case: the rounding mode decides how an odd sum is shifted.
    pulse_reset();
    load_coef(0, 1);
    send(0, 3, 0, 0, 0, a);
`ifdef FIR_ROUND_EN
    check("pin_single_tap", sat_of(a, 20), 2);
`else
    check("pin_single_tap", sat_of(a, 20), 1);
`endif
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
